// File: rtl/cache_arbiter_if.sv
// rtl/cache_arbiter_if.sv - I-cache, D-cache and downstream line-port signals of the arbiter
interface cache_arbiter_if #(
    parameter int LINE_WIDTH = 256,
    parameter int ADDR_WIDTH = 32
);
    logic                  i_pmem_read;
    logic [ADDR_WIDTH-1:0] i_pmem_address;
    logic [LINE_WIDTH-1:0] i_pmem_rdata;
    logic                  i_pmem_resp;

    logic                  d_pmem_read;
    logic                  d_pmem_write;
    logic [ADDR_WIDTH-1:0] d_pmem_address;
    logic [LINE_WIDTH-1:0] d_pmem_wdata;
    logic [LINE_WIDTH-1:0] d_pmem_rdata;
    logic                  d_pmem_resp;

    logic                  mem_read;
    logic                  mem_write;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [LINE_WIDTH-1:0] mem_wdata;
    logic [LINE_WIDTH-1:0] mem_rdata;
    logic                  mem_resp;

    modport master (
        output i_pmem_read, i_pmem_address,
        input  i_pmem_rdata, i_pmem_resp,
        output d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
        input  d_pmem_rdata, d_pmem_resp,
        input  mem_read, mem_write, mem_address, mem_wdata,
        output mem_rdata, mem_resp
    );

    modport slave (
        input  i_pmem_read, i_pmem_address,
        output i_pmem_rdata, i_pmem_resp,
        input  d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
        output d_pmem_rdata, d_pmem_resp,
        output mem_read, mem_write, mem_address, mem_wdata,
        input  mem_rdata, mem_resp
    );
endinterface

// File: rtl/cache_arbiter.sv
// rtl/cache_arbiter.sv - round-robin arbiter sharing one line port between I-cache and D-cache
module cache_arbiter #(
    parameter int LINE_WIDTH = 256,
    parameter int ADDR_WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst,
    cache_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RECOVER} state_t;

    state_t                state;
    logic                  last_d;
    logic                  cmd_read;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LINE_WIDTH-1:0] wdata_q;

    logic i_req;
    logic d_req;
    logic grant_d;

    assign i_req   = bus.i_pmem_read;
    assign d_req   = bus.d_pmem_read | bus.d_pmem_write;
    // On a tie the grant goes to whichever side did not win last time.
    assign grant_d = d_req & (~i_req | ~last_d);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            last_d    <= 1'b1;
            cmd_read  <= 1'b0;
            cmd_write <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state     <= SERVE_D;
                        last_d    <= 1'b1;
                        addr_q    <= bus.d_pmem_address;
                        wdata_q   <= bus.d_pmem_wdata;
                        cmd_write <= bus.d_pmem_write;
                        cmd_read  <= ~bus.d_pmem_write;
                    end else if (i_req) begin
                        state     <= SERVE_I;
                        last_d    <= 1'b0;
                        addr_q    <= bus.i_pmem_address;
                        cmd_read  <= 1'b1;
                        cmd_write <= 1'b0;
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (bus.mem_resp) begin
                        state     <= RECOVER;
                        cmd_read  <= 1'b0;
                        cmd_write <= 1'b0;
                    end
                end
                RECOVER: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mem_read    = cmd_read;
    assign bus.mem_write   = cmd_write;
    assign bus.mem_address = addr_q;
    assign bus.mem_wdata   = wdata_q;

    // Completion is forwarded combinationally, and only to the side being served.
    assign bus.i_pmem_resp  = (state == SERVE_I) & bus.mem_resp;
    assign bus.d_pmem_resp  = (state == SERVE_D) & bus.mem_resp;
    assign bus.i_pmem_rdata = (state == SERVE_I) ? bus.mem_rdata : '0;
    assign bus.d_pmem_rdata = (state == SERVE_D) ? bus.mem_rdata : '0;
endmodule
